ps2_keyboard_rx: RTL
====================

PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 SHALL have port CLK  input  1  system clock (16 MHz); all state changes on its rising edge.
REQ-002 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-003 SHALL have port CLK_en  input  1  sample enable; filter, edge detect and timeout advance only when high.
REQ-004 SHALL have port PS2_CLK  input  1  raw, asynchronous keyboard clock.
REQ-005 SHALL have port PS2_DATA  input  1  raw, asynchronous keyboard data.
REQ-006 SHALL have port KEY_CODE  output  8  last decoded non-prefix scan code.
REQ-007 SHALL have port KEY_BREAK  output  1  KEY_CODE is a release (F0 prefix seen).
REQ-008 SHALL have port KEY_EXT  output  1  KEY_CODE is extended (E0 prefix seen).
REQ-009 SHALL have port KEY_VALID  output  1  one-CLK pulse when KEY_CODE/KEY_BREAK/KEY_EXT update.
REQ-010 SHALL have port FRAME_ERR  output  1  one-CLK pulse on start/parity/stop error or timeout.
REQ-011 SHALL have parameter FILTER_LEN, default 8, number of consecutive equal samples needed to change the filtered clock.
REQ-012 SHALL have parameter TIMEOUT, default 2048, CLK_en cycles without a falling edge before a frame is aborted.

Function
REQ-013 SHALL register PS2_CLK and PS2_DATA through two CLK flops before any use.
REQ-014 SHALL change the filtered clock only after FILTER_LEN consecutive equal synchronised samples taken on CLK_en cycles; shorter pulses are ignored.
REQ-015 SHALL sample synchronised PS2_DATA on each filtered-clock falling edge.
REQ-016 SHALL implement states IDLE, DATA, PARITY, STOP.
REQ-017 IDLE: a falling edge with data 0 moves to DATA; a falling edge with data 1 stays in IDLE and pulses FRAME_ERR.
REQ-018 DATA: shift in 8 bits LSB first; after the 8th bit go to PARITY.
REQ-019 PARITY: odd parity over 8 data bits plus parity bit; mismatch is latched and the FSM goes to STOP.
REQ-020 STOP: on the falling edge, data 1 with no parity error completes the frame; otherwise pulse FRAME_ERR and emit nothing. Return to IDLE in both cases.
REQ-021 SHALL treat completed byte F0 as a prefix: set the pending-break flag and emit no KEY_VALID.
REQ-022 On any other completed byte, SHALL load KEY_CODE, set KEY_BREAK/KEY_EXT from the pending flags, pulse KEY_VALID on the next CLK edge, and clear the pending flags.
REQ-023 KEY_CODE/KEY_BREAK/KEY_EXT SHALL hold between KEY_VALID pulses.
REQ-024 In a non-IDLE state, TIMEOUT CLK_en cycles without a falling edge SHALL pulse FRAME_ERR and force IDLE.
REQ-025 FRAME_ERR and timeout SHALL clear the pending prefix flags.
REQ-026 KEY_VALID and FRAME_ERR SHALL never assert in the same cycle.
REQ-027 If CLK_en is low, SHALL freeze the filter, timeout counter and FSM; output pulses already scheduled still complete.

Reset
REQ-028 RESET SHALL force IDLE and clear the bit counter, shift register, timeout counter and prefix flags, set the filtered clock to 1, and set all outputs to 0.
REQ-029 RESET asserted mid-frame SHALL discard the partial frame; the next start bit after release decodes normally.

Configuration
REQ-030 With PS2_EXTENDED_EN defined, completed byte E0 SHALL set the pending-extended flag and emit no KEY_VALID.
REQ-031 Without PS2_EXTENDED_EN, E0 SHALL be emitted as an ordinary KEY_CODE and KEY_EXT SHALL be tied to 0.

Structure
REQ-032 A shared package ps2_pkg SHALL hold the PS2_BREAK_CODE (F0) and PS2_EXT_CODE (E0) constants, the FSM state encoding, and the default FILTER_LEN/TIMEOUT values.
REQ-033 The synchroniser, glitch filter and falling-edge detector SHALL be a sub-module, ps2_clk_filter.

Verification
REQ-034 Frame 1C, correct parity -> exactly one KEY_VALID, KEY_CODE=1C, KEY_BREAK=0, KEY_EXT=0.
REQ-035 Frames F0 then 1C -> no pulse after F0; one KEY_VALID with KEY_CODE=1C, KEY_BREAK=1.
REQ-036 Frame 5A with inverted parity bit -> FRAME_ERR pulse, no KEY_VALID; next clean 5A -> KEY_CODE=5A.
REQ-037 Stop after 5 data bits for more than 2048 CLK_en cycles -> FRAME_ERR, state IDLE; next frame 45 -> KEY_CODE=45.
REQ-038 3-sample low glitch on PS2_CLK during IDLE -> no state change, no pulses.
REQ-039 Frames E0 F0 75 -> with PS2_EXTENDED_EN: one KEY_VALID with KEY_CODE=75, KEY_EXT=1, KEY_BREAK=1; without it: KEY_VALID for E0, then for 75 with KEY_BREAK=1.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and parity helper for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK_CODE     = 8'hF0;
    localparam logic [7:0] PS2_EXT_CODE       = 8'hE0;
    localparam int         PS2_FILTER_LEN_DEF = 8;
    localparam int         PS2_TIMEOUT_DEF    = 2048;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // Odd parity: the eight data bits plus the parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronises PS2_CLK/PS2_DATA, debounces the clock and flags filtered falling edges.
module ps2_clk_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = PS2_FILTER_LEN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_en,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_sync,
    output logic clk_fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    data_sync_q, data_sync_d;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          change;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            cnt_q       <= '0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_q      <= filt_d;
            cnt_q       <= cnt_d;
        end
    end

    // cnt_q counts consecutive enabled samples that disagree with the filtered level.
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        filt_d      = filt_q;
        cnt_d       = cnt_q;
        change      = 1'b0;
        if (clk_en) begin
            if (clk_sync_q[1] == filt_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                change = 1'b1;
                filt_d = clk_sync_q[1];
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign data_sync = data_sync_q[1];
    assign clk_fall  = change & filt_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard frame receiver with F0 break-prefix handling.
// Defining PS2_EXTENDED_EN makes E0 an extended-key prefix instead of an ordinary code.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = PS2_FILTER_LEN_DEF,
    parameter int TIMEOUT    = PS2_TIMEOUT_DEF
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_en,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] KEY_CODE,
    output logic       KEY_BREAK,
    output logic       KEY_EXT,
    output logic       KEY_VALID,
    output logic       FRAME_ERR,
    output logic [1:0] dbg_state
);

    localparam int TW = $clog2(TIMEOUT + 1);

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_err_q, par_err_d;
    logic [TW-1:0] tout_q, tout_d;
    logic          brk_pend_q, brk_pend_d;
    logic [7:0]    code_q, code_d;
    logic          break_q, break_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          data_s, fall, timeout_hit;
`ifdef PS2_EXTENDED_EN
    logic          ext_pend_q, ext_pend_d;
    logic          ext_q, ext_d;
`endif

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk       (CLK),
        .reset     (RESET),
        .clk_en    (CLK_en),
        .ps2_clk   (PS2_CLK),
        .ps2_data  (PS2_DATA),
        .data_sync (data_s),
        .clk_fall  (fall)
    );

    // A falling edge arriving on the final count still counts as activity.
    assign timeout_hit = CLK_en && (state_q != ST_IDLE) && !fall
                         && (tout_q == TW'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (RESET) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (timeout_hit) begin
            state_d = ST_IDLE;
        end else if (fall) begin
            case (state_q)
                ST_IDLE:   if (!data_s) state_d = ST_DATA;
                ST_DATA:   if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                ST_PARITY: state_d = ST_STOP;
                ST_STOP:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            tout_q     <= '0;
            brk_pend_q <= 1'b0;
            code_q     <= '0;
            break_q    <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
`ifdef PS2_EXTENDED_EN
            ext_pend_q <= 1'b0;
            ext_q      <= 1'b0;
`endif
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_err_q  <= par_err_d;
            tout_q     <= tout_d;
            brk_pend_q <= brk_pend_d;
            code_q     <= code_d;
            break_q    <= break_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
`ifdef PS2_EXTENDED_EN
            ext_pend_q <= ext_pend_d;
            ext_q      <= ext_d;
`endif
        end
    end

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        tout_d     = tout_q;
        brk_pend_d = brk_pend_q;
        code_d     = code_q;
        break_d    = break_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
`ifdef PS2_EXTENDED_EN
        ext_pend_d = ext_pend_q;
        ext_d      = ext_q;
`endif
        if (CLK_en) begin
            if (state_q == ST_IDLE || fall) tout_d = '0;
            else                            tout_d = tout_q + TW'(1);
        end
        if (timeout_hit) begin
            err_d      = 1'b1;
            brk_pend_d = 1'b0;
`ifdef PS2_EXTENDED_EN
            ext_pend_d = 1'b0;
`endif
        end else if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (data_s) begin
                        err_d      = 1'b1;
                        brk_pend_d = 1'b0;
`ifdef PS2_EXTENDED_EN
                        ext_pend_d = 1'b0;
`endif
                    end else begin
                        bit_cnt_d = '0;
                        par_err_d = 1'b0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                ST_PARITY: par_err_d = !odd_parity_ok(shift_q, data_s);
                ST_STOP: begin
                    if (data_s && !par_err_q) begin
                        if (shift_q == PS2_BREAK_CODE) begin
                            brk_pend_d = 1'b1;
`ifdef PS2_EXTENDED_EN
                        end else if (shift_q == PS2_EXT_CODE) begin
                            ext_pend_d = 1'b1;
`endif
                        end else begin
                            code_d     = shift_q;
                            break_d    = brk_pend_q;
                            valid_d    = 1'b1;
                            brk_pend_d = 1'b0;
`ifdef PS2_EXTENDED_EN
                            ext_d      = ext_pend_q;
                            ext_pend_d = 1'b0;
`endif
                        end
                    end else begin
                        err_d      = 1'b1;
                        brk_pend_d = 1'b0;
`ifdef PS2_EXTENDED_EN
                        ext_pend_d = 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign KEY_CODE  = code_q;
    assign KEY_BREAK = break_q;
    assign KEY_VALID = valid_q;
    assign FRAME_ERR = err_q;
    assign dbg_state = state_q;
`ifdef PS2_EXTENDED_EN
    assign KEY_EXT   = ext_q;
`else
    assign KEY_EXT   = 1'b0;
`endif

endmodule
